serial_adder_seq: RTL and testbench
===================================

// Module: serial_adder_seq
// PURPOSE
//   Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock,
//   through a single full-adder cell and a carry flop.
//   Sits between operand sources and gate-level datapath consumers.
//   Trades throughput for area against a ripple adder.
//   Start/done handshake. Result is held until the next operation starts.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk    in   1       single clock, rising edge
//   rst    in   1       synchronous reset, active-high
//   start  in   1       request; sampled only in IDLE
//   a      in   WIDTH   operand A, captured when start accepted
//   b      in   WIDTH   operand B, captured when start accepted
//   cin    in   1       carry-in, captured when start accepted
//   busy   out  1       high while in RUN
//   done   out  1       one-cycle pulse: result valid
//   sum    out  WIDTH   result (a+b+cin) mod 2^WIDTH, held
//   cout   out  1       carry out of bit WIDTH-1, held
//   ovf    out  1       signed overflow, held (only with SERIAL_ADD_OVF_EN)
// BEHAVIOUR
//   Clocking/reset: one clock (clk); reset synchronous, active-high (rst).
//   Reset (any state, incl. mid-RUN): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
//     Internal shift regs, carry and counter are cleared; the in-flight op is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0:
//     - load A<=a, B<=b, C<=cin, cnt<=0; go to RUN.
//     - otherwise stay; outputs hold.
//   RUN, each edge (E1..E_WIDTH):
//     - s  = A[0]^B[0]^C
//     - C <= (A[0]&B[0]) | (C&(A[0]^B[0]))
//     - S <= {s, S[WIDTH-1:1]}; A,B shift right; cnt++
//     - at edge with cnt==WIDTH-1: sum<={s,S[WIDTH-1:1]}, cout<=new carry; go to DONE.
//   DONE: done=1 for exactly this cycle; next edge -> IDLE unconditionally.
//   Latency: done high in the cycle after E_WIDTH; a new start is accepted from E_WIDTH+2.
//   busy=1 exactly in cycles following E0..E_WIDTH-1 (RUN); busy=0 in IDLE and DONE.
//   start in RUN or DONE: ignored, not queued. Operand changes after E0 have no effect.
//   sum/cout change only on entry to DONE (or reset); stable otherwise.
//   Back-to-back start held high: one op per WIDTH+2 cycles.
//   cnt width = clog2(WIDTH); no wrap beyond WIDTH-1.
// CONFIGURATION
//   SERIAL_ADD_OVF_EN defined:
//     - port ovf present; on entry to DONE, ovf <= carry into bit WIDTH-1 XOR cout
//       (two's-complement overflow).
//     - reset 0; held like sum.
//   SERIAL_ADD_OVF_EN undefined:
//     - port ovf and its logic absent; all other behaviour identical.
// TESTING (WIDTH=8)
//   1. a=0x0F, b=0x01, cin=0, start at E0 -> busy E0..E7; done in cycle after E8;
//      sum=0x10, cout=0.
//   2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 (with macro).
//      a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
//   3. a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
//      start held high -> next done exactly 10 cycles later.
//   4. start pulsed at E3 mid-RUN, a/b changed -> ignored; result of first op unchanged;
//      only one done pulse.
//   5. rst at E4 mid-RUN -> next cycle busy=0, done=0, sum=0, cout=0;
//      no done pulse; new start at E6 completes normally.
//   6. Build without SERIAL_ADD_OVF_EN: tests 1-5 pass (ovf checks skipped);
//      elaboration shows no ovf port.

Source files
------------

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder with start/done handshake; optional ovf via SERIAL_ADD_OVF_EN
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;

    // Single full-adder cell working on the LSBs of the operand shift registers
    always_comb begin
        bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last_bit  = (cnt == LAST_CNT);
    end

    // Control FSM plus datapath shift registers; all outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        s_sh  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // One result bit per cycle enters at the MSB and walks down
                    s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nxt;
                    if (last_bit) begin
                        sum   <= {bit_s, s_sh[WIDTH-1:1]};
                        cout  <= carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
                        // carry holds the carry into the MSB on this edge
                        ovf   <= carry ^ carry_nxt;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // Start is ignored here; the next op can only begin from IDLE
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - self-checking bench for serial_adder_seq
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_obs;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf_obs)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: plain integer addition and the sign rule for overflow
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] full;
        logic       v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    task automatic check_result(input string nm, input logic [W-1:0] es, input logic ec,
                                input logic ev);
        checks++;
        if (sum !== es || cout !== ec) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b, expected sum=%h cout=%b", nm, sum, cout, es, ec);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf_obs !== ev) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", nm, ovf_obs, ev);
        end
`endif
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input bit scramble);
        logic [W+1:0] e;
        e = model(ta, tb_, tc);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b, expected 0/0", nm, busy, done);
        end
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scramble) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum) begin
                errors++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b sum=%h, expected 1/0/%h",
                         nm, i, busy, done, sum, prev_sum);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: done=%b busy=%b, expected 1/0", nm, done, busy);
        end
        check_result(nm, e[W-1:0], e[W], e[W+1]);
        prev_sum = e[W-1:0]; prev_cout = e[W]; prev_ovf = e[W+1];
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sum !== prev_sum || cout !== prev_cout) begin
            errors++;
            $display("FAIL %s after done: done=%b sum=%h cout=%b, expected 0/%h/%b",
                     nm, done, sum, cout, prev_sum, prev_cout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_result("reset", '0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: busy=%b done=%b, expected 0/0", busy, done);
        end
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    endtask

    task automatic test_directed();
        do_op("t1_0f_01", 8'h0F, 8'h01, 1'b0, 1'b1);
        do_op("t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1);
        do_op("t2_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1);
        do_op("t3_aa_55", 8'hAA, 8'h55, 1'b1, 1'b1);
        do_op("neg_ovf", 8'h80, 8'h80, 1'b0, 1'b0);
        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            do_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_start_ignored();
        logic [W+1:0] e;
        int extra;
        e = model(8'h33, 8'h44, 1'b0);
        @(negedge clk);
        a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL midstart run %0d: busy=%b done=%b, expected 1/0", i, busy, done);
            end
            if (i == 2) begin
                start = 1'b1; a = 8'hF0; b = 8'hF0; cin = 1'b1;
            end
            if (i == 3) start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midstart done: got %b expected 1", done);
        end
        check_result("midstart", e[W-1:0], e[W], e[W+1]);
        prev_sum = e[W-1:0]; prev_cout = e[W]; prev_ovf = e[W+1];
        extra = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midstart queued: %0d active cycles after op, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        do_op("pre_reset", 8'h0F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset flags: busy=%b done=%b, expected 0/0", busy, done);
        end
        check_result("midreset", '0, 1'b0, 1'b0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        do_op("post_reset", 8'h12, 8'h34, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q[$];
        logic [W-1:0] ta, tb_;
        logic         tc;
        int cyc, last, seen;
        ta = W'($urandom); tb_ = W'($urandom); tc = 1'($urandom);
        exp_q.push_back(model(ta, tb_, tc));
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        cyc = 0; last = 0; seen = 0;
        while (seen < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                check_result("b2b", exp_q[0][W-1:0], exp_q[0][W], exp_q[0][W+1]);
                prev_sum = exp_q[0][W-1:0]; prev_cout = exp_q[0][W]; prev_ovf = exp_q[0][W+1];
                void'(exp_q.pop_front());
                if (seen > 0) begin
                    checks++;
                    if (cyc - last != W + 2) begin
                        errors++;
                        $display("FAIL b2b spacing: %0d cycles, expected %0d", cyc - last, W + 2);
                    end
                end
                last = cyc;
                seen++;
                ta = W'($urandom); tb_ = W'($urandom); tc = 1'($urandom);
                exp_q.push_back(model(ta, tb_, tc));
                a = ta; b = tb_; cin = tc;
                if (seen == 3) start = 1'b0;
            end
        end
        checks++;
        if (seen != 3) begin
            errors++;
            $display("FAIL b2b timeout: %0d done pulses, expected 3", seen);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
